// File: rtl/usb3_tp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : usb3_tp_arbiter
// Description : Shares the link layer's transaction-packet transmit port
//               between three protocol-layer requesters. Requester 0 (ACK
//               responder) has strict priority. Requesters 1 (status) and
//               2 (flow control) alternate round-robin. Each launch waits
//               for completion, or for a timeout, and is followed by an
//               inter-packet gap before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module usb3_tp_arbiter #(
    parameter int MIN_GAP = 2,     // idle cycles after each TP, 0..255
    parameter int TIMEOUT = 512    // completion wait limit, 1..65535
) (
    input  logic         local_clk,
    input  logic         reset,
    input  logic [4:0]   ltssm_state,
    input  logic [2:0]   req_valid,
    input  logic [107:0] req_tp,
    output logic [2:0]   req_ack,
    output logic         tx_tp,
    output logic         tx_tp_retry,
    output logic         tx_tp_dir,
    output logic [3:0]   tx_tp_subtype,
    output logic [3:0]   tx_tp_endp,
    output logic [4:0]   tx_tp_nump,
    output logic [4:0]   tx_tp_seq,
    output logic [15:0]  tx_tp_stream,
    input  logic         tx_tp_done,
    output logic         busy,
    output logic         err_timeout
);

    // LTSSM encoding of U0, matching LT_U0 in usb3_const.vh
    localparam logic [4:0]  c_LT_U0        = 5'd16;

    localparam logic [1:0]  c_ST_IDLE      = 2'd0;
    localparam logic [1:0]  c_ST_WAIT_DONE = 2'd1;
    localparam logic [1:0]  c_ST_GAP       = 2'd2;

    // Timer value on the last permitted completion-wait cycle
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);
    // Gap counter value on the last GAP cycle; MIN_GAP = 0 still spends one
    // cycle in GAP because the exit is taken on the next edge
    localparam logic [7:0]  c_GAP_LAST     = (MIN_GAP == 0) ? 8'd0 : 8'(MIN_GAP - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_rr;
    logic [15:0] r_timer;
    logic [7:0]  r_gap_cnt;
    logic        r_err;
    logic [2:0]  r_req_ack;
    logic        r_tx_tp;
    logic [35:0] r_fields;

    logic        w_u0;
    logic [2:0]  w_grant_vec;
    logic        w_grant;
    logic [35:0] w_grant_tp;
    logic        w_timeout_hit;
    logic        w_enter_gap;

    assign w_u0          = (ltssm_state == c_LT_U0);
    assign w_grant       = |w_grant_vec;
    assign w_timeout_hit = (r_state == c_ST_WAIT_DONE) && (r_timer == c_TIMEOUT_LAST);
    assign w_enter_gap   = (r_state == c_ST_WAIT_DONE) && (w_state_next == c_ST_GAP);

    // State register
    always_ff @(posedge local_clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: done beats timeout, timeout beats link-state exit
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = c_ST_WAIT_DONE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (tx_tp_done || w_timeout_hit || !w_u0) begin
                    w_state_next = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // Output/arbitration logic: pick the winner in IDLE and select its fields
    always_comb begin
        w_grant_vec = 3'b000;
        w_grant_tp  = 36'd0;
        if ((r_state == c_ST_IDLE) && w_u0) begin
            if (req_valid[0]) begin
                w_grant_vec = 3'b001;
            end else if (req_valid[1] && req_valid[2]) begin
                w_grant_vec = r_rr ? 3'b100 : 3'b010;
            end else if (req_valid[1]) begin
                w_grant_vec = 3'b010;
            end else if (req_valid[2]) begin
                w_grant_vec = 3'b100;
            end
        end
        case (w_grant_vec)
            3'b001:  w_grant_tp = req_tp[35:0];
            3'b010:  w_grant_tp = req_tp[71:36];
            3'b100:  w_grant_tp = req_tp[107:72];
            default: w_grant_tp = 36'd0;
        endcase
    end

    // Grant side: ack/launch pulses, field latch and round-robin pointer
    always_ff @(posedge local_clk) begin
        if (reset) begin
            r_req_ack <= 3'b000;
            r_tx_tp   <= 1'b0;
            r_fields  <= 36'd0;
            r_rr      <= 1'b0;
        end else begin
            r_req_ack <= w_grant_vec;
            r_tx_tp   <= w_grant;
            if (w_grant) begin
                r_fields <= w_grant_tp;
                if (w_grant_vec[1]) begin
                    r_rr <= 1'b1;
                end else if (w_grant_vec[2]) begin
                    r_rr <= 1'b0;
                end
            end
        end
    end

    // Completion timer, gap counter and sticky timeout flag
    always_ff @(posedge local_clk) begin
        if (reset) begin
            r_timer   <= 16'd0;
            r_gap_cnt <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_timer <= 16'd0;
            end else if ((r_state == c_ST_WAIT_DONE) && (r_timer != 16'hFFFF)) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_enter_gap) begin
                r_gap_cnt <= 8'd0;
                if (!tx_tp_done && w_timeout_hit) begin
                    r_err <= 1'b1;
                end
            end else if ((r_state == c_ST_GAP) && (r_gap_cnt != 8'hFF)) begin
                r_gap_cnt <= r_gap_cnt + 8'd1;
            end
        end
    end

    assign req_ack       = r_req_ack;
    assign tx_tp         = r_tx_tp;
    assign tx_tp_retry   = r_fields[35];
    assign tx_tp_dir     = r_fields[34];
    assign tx_tp_subtype = r_fields[33:30];
    assign tx_tp_endp    = r_fields[29:26];
    assign tx_tp_nump    = r_fields[25:21];
    assign tx_tp_seq     = r_fields[20:16];
    assign tx_tp_stream  = r_fields[15:0];
    assign busy          = (r_state != c_ST_IDLE);
    assign err_timeout   = r_err;

endmodule
`default_nettype wire
